// File: rtl/snake_sequencer.sv
// ----------------------------------------------------------------------------
// snake_sequencer
//   Generates game ticks for the snake core, converts button presses into a
//   two-entry direction queue, and runs a request/acknowledge handshake that
//   asks the core to move the snake one cell per tick.
//
// Ports
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   Clear      in   synchronous restart request from the game FSM
//   Run        in   level, high while game ticks should be generated
//   Period     in   [PERIOD_W-1:0] Clk cycles per tick (0 behaves as 1)
//   Left/Right/Up/Down  in  debounced button levels
//   StepAck    in   one-cycle acknowledge of a step from the core
//   StepReq    out  step request, high for the whole handshake
//   Dir        out  [1:0] move direction: LEFT=00 RIGHT=01 UP=10 DOWN=11
//   QueueCount out  [1:0] number of queued directions (0..2)
//   Overrun    out  sticky: a tick expired while a step was unacknowledged
//   StepCount  out  [15:0] acknowledged steps, wrapping
// ----------------------------------------------------------------------------
module snake_sequencer #(
    parameter int PERIOD_W = 24,
    parameter int QDEPTH   = 2      // only a depth of 2 is supported
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Clear,
    input  logic                Run,
    input  logic [PERIOD_W-1:0] Period,
    input  logic                Left,
    input  logic                Right,
    input  logic                Up,
    input  logic                Down,
    input  logic                StepAck,
    output logic                StepReq,
    output logic [1:0]          Dir,
    output logic [1:0]          QueueCount,
    output logic                Overrun,
    output logic [15:0]         StepCount
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [PERIOD_W-1:0] LP_ONE  = PERIOD_W'(1);
    localparam logic [1:0]          LP_FULL = 2'(QDEPTH);

    logic [1:0]          r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic [3:0]          r_btn_prev;
    logic [1:0]          r_q0;          // queue head
    logic [1:0]          r_q1;
    logic [1:0]          r_qcnt;
    logic [1:0]          r_dir;
    logic                r_overrun;
    logic [15:0]         r_steps;

    logic [3:0]          w_btn;
    logic [3:0]          w_rise;
    logic                w_press_vld;
    logic [1:0]          w_press_dir;
    logic [PERIOD_W-1:0] w_last;
    logic                w_cnt_hit;
    logic                w_tick_pop;
    logic [1:0]          w_ref;
    logic                w_full;
    logic                w_accept;
    logic [1:0]          w_q0_n;
    logic [1:0]          w_q1_n;
    logic [1:0]          w_qcnt_n;

    // Bit index equals the direction code, so the priority pick below is
    // simply the lowest set rising-edge bit.
    assign w_btn       = {Down, Up, Right, Left};
    assign w_rise      = w_btn & ~r_btn_prev;
    assign w_press_vld = |w_rise;

    always_comb begin
        w_press_dir = DIR_DOWN;
        if (w_rise[0])
            w_press_dir = DIR_LEFT;
        else if (w_rise[1])
            w_press_dir = DIR_RIGHT;
        else if (w_rise[2])
            w_press_dir = DIR_UP;
    end

    assign w_last     = (Period == '0) ? '0 : (Period - LP_ONE);
    assign w_cnt_hit  = (r_cnt == w_last);
    assign w_tick_pop = (r_state == ST_WAIT) && Run && w_cnt_hit && (r_qcnt != 2'd0);

    assign w_ref  = (r_qcnt == 2'd0) ? r_dir :
                    (r_qcnt == 2'd1) ? r_q0  : r_q1;
    assign w_full = (r_qcnt == LP_FULL);

    // A press matching bit 1 of the reference is either the same direction
    // or its reverse; both are dropped, so only the axis bit matters.
    assign w_accept = w_press_vld && (w_press_dir[1] != w_ref[1]) &&
                      (!w_full || w_tick_pop);

    // Pop first, then append to whatever remains, so a same-cycle pop and
    // push leave the count unchanged.
    always_comb begin
        w_q0_n   = r_q0;
        w_q1_n   = r_q1;
        w_qcnt_n = r_qcnt;
        if (w_tick_pop) begin
            w_q0_n   = r_q1;
            w_qcnt_n = r_qcnt - 2'd1;
        end
        if (w_accept) begin
            if (w_qcnt_n == 2'd0)
                w_q0_n = w_press_dir;
            else
                w_q1_n = w_press_dir;
            w_qcnt_n = w_qcnt_n + 2'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_btn_prev <= '0;
            r_q0       <= DIR_LEFT;
            r_q1       <= DIR_LEFT;
            r_qcnt     <= 2'd0;
            r_dir      <= DIR_RIGHT;
            r_overrun  <= 1'b0;
            r_steps    <= '0;
        end else begin
            r_btn_prev <= w_btn;
            if (Clear) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_q0      <= DIR_LEFT;
                r_q1      <= DIR_LEFT;
                r_qcnt    <= 2'd0;
                r_dir     <= DIR_RIGHT;
                r_overrun <= 1'b0;
                r_steps   <= '0;
            end else begin
                r_q0   <= w_q0_n;
                r_q1   <= w_q1_n;
                r_qcnt <= w_qcnt_n;
                if (w_tick_pop)
                    r_dir <= r_q0;

                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= '0;
                        if (Run)
                            r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (!Run) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (w_cnt_hit) begin
                            r_state <= ST_REQ;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + LP_ONE;
                        end
                    end
                    ST_REQ: begin
                        // The tick counter keeps running through the
                        // handshake so tick spacing does not depend on how
                        // fast the core acknowledges.
                        if (StepAck) begin
                            r_steps <= r_steps + 16'd1;
                            if (Run) begin
                                r_state <= ST_WAIT;
                                r_cnt   <= w_cnt_hit ? '0 : (r_cnt + LP_ONE);
                            end else begin
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                            end
                        end else if (w_cnt_hit) begin
                            r_overrun <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + LP_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign StepReq    = (r_state == ST_REQ);
    assign Dir        = r_dir;
    assign QueueCount = r_qcnt;
    assign Overrun    = r_overrun;
    assign StepCount  = r_steps;

endmodule

// File: tb/tb_snake_sequencer.sv
// ----------------------------------------------------------------------------
// tb_snake_sequencer
//   Directed bench for snake_sequencer. A cycle-level reference model built on
//   a direction queue and a few booleans is compared against every output on
//   every cycle outside reset; directed checks with hand-computed literals pin
//   the tick latency, queue filtering, overrun and clear/reset behaviour.
// ----------------------------------------------------------------------------
module tb_snake_sequencer;

    localparam int PW = 24;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Clear = 1'b0;
    logic          Run = 1'b0;
    logic [PW-1:0] Period = '0;
    logic          Left = 1'b0, Right = 1'b0, Up = 1'b0, Down = 1'b0;
    logic          StepAck = 1'b0;
    logic          StepReq;
    logic [1:0]    Dir;
    logic [1:0]    QueueCount;
    logic          Overrun;
    logic [15:0]   StepCount;

    snake_sequencer #(.PERIOD_W(PW), .QDEPTH(2)) dut (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .Run(Run), .Period(Period),
        .Left(Left), .Right(Right), .Up(Up), .Down(Down), .StepAck(StepAck),
        .StepReq(StepReq), .Dir(Dir), .QueueCount(QueueCount),
        .Overrun(Overrun), .StepCount(StepCount)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    bit       m_active;     // tick timing is running
    bit       m_pending;    // a step has been requested, not yet acknowledged
    int       m_phase;      // cycles elapsed in the current tick period
    int       m_dir;
    int       mq[$];
    bit       m_ovr;
    int       m_steps;
    bit [3:0] m_prev;

    function automatic void model_reset();
        m_active = 0; m_pending = 0; m_phase = 0; m_dir = 1;
        mq.delete(); m_ovr = 0; m_steps = 0; m_prev = '0;
    endfunction

    function automatic void model_step();
        bit [3:0] btn;
        int per, press, refd;
        bit tick, pop, acc, wrap;
        btn = {Down, Up, Right, Left};
        if (Clear) begin
            m_active = 0; m_pending = 0; m_phase = 0; m_dir = 1;
            mq.delete(); m_ovr = 0; m_steps = 0; m_prev = btn;
            return;
        end
        per = (Period == 0) ? 1 : int'(Period);
        press = -1;
        for (int i = 0; i < 4; i++)
            if (btn[i] && !m_prev[i] && press < 0) press = i;
        m_prev = btn;
        refd = (mq.size() > 0) ? mq[$] : m_dir;
        tick = m_active && !m_pending && Run && (m_phase == per - 1);
        pop  = tick && (mq.size() > 0);
        acc  = (press >= 0) && ((press >> 1) != (refd >> 1)) && (mq.size() < 2 || pop);
        if (pop) m_dir = mq.pop_front();
        if (acc) mq.push_back(press);

        if (!m_active) begin
            m_phase = 0;
            if (Run) m_active = 1;
        end else if (!m_pending) begin
            if (!Run) begin
                m_active = 0; m_phase = 0;
            end else if (tick) begin
                m_pending = 1; m_phase = 0;
            end else m_phase++;
        end else begin
            wrap = (m_phase == per - 1);
            if (StepAck) begin
                m_steps = (m_steps + 1) & 16'hFFFF;
                m_pending = 0;
                if (!Run) begin
                    m_active = 0; m_phase = 0;
                end else m_phase = wrap ? 0 : m_phase + 1;
            end else if (wrap) begin
                m_ovr = 1; m_phase = 0;
            end else m_phase++;
        end
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) model_reset();
        else       model_step();
    end

    always @(posedge Clk) begin
        #1;
        if (!Reset) begin
            chk("model StepReq", int'(StepReq), int'(m_pending));
            chk("model Dir", int'(Dir), m_dir);
            chk("model QueueCount", int'(QueueCount), mq.size());
            chk("model Overrun", int'(Overrun), int'(m_ovr));
            chk("model StepCount", int'(StepCount), m_steps);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_req(output int at_cyc);
        at_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge Clk); #1;
            if (StepReq) begin
                at_cyc = cyc;
                return;
            end
        end
        chk("StepReq timeout", 0, 1);
    endtask

    task automatic ack();
        @(negedge Clk); StepAck = 1'b1;
        @(negedge Clk); StepAck = 1'b0;
    endtask

    task automatic set_btn(input bit l, input bit r, input bit u, input bit d);
        @(negedge Clk);
        Left = l; Right = r; Up = u; Down = d;
    endtask

    int t_run, r1, r2, r3;

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset StepReq", int'(StepReq), 0);
        chk("reset Dir", int'(Dir), 1);
        chk("reset QueueCount", int'(QueueCount), 0);
        chk("reset Overrun", int'(Overrun), 0);
        chk("reset StepCount", int'(StepCount), 0);
        Reset = 1'b0;

        // Period 4, steady run, ack one cycle after each request
        @(negedge Clk); Period = 4; Run = 1'b1; t_run = cyc;
        wait_req(r1); chk("latency P=4", r1 - t_run, 5); ack();
        wait_req(r2); chk("spacing P=4 a", r2 - r1, 4); ack();
        wait_req(r3); chk("spacing P=4 b", r3 - r2, 4); ack();
        chk("steps after 3", int'(StepCount), 3);
        chk("no overrun", int'(Overrun), 0);

        // Left (reverse) dropped, Up queued, Down (reverse of tail) dropped
        Period = 20;
        set_btn(1, 0, 0, 0);
        set_btn(1, 0, 1, 0);
        set_btn(1, 0, 1, 1);
        set_btn(0, 0, 0, 0);
        @(negedge Clk);
        chk("filter QueueCount", int'(QueueCount), 1);
        chk("filter Dir still RIGHT", int'(Dir), 1);
        wait_req(r1);
        chk("tick Dir UP", int'(Dir), 2);
        chk("tick queue empty", int'(QueueCount), 0);
        ack();

        // Left and Up together with Dir=UP: Left wins, hold gives no repeat
        set_btn(1, 0, 1, 0);
        @(negedge Clk); chk("priority QueueCount", int'(QueueCount), 1);
        repeat (2) @(negedge Clk);
        chk("held QueueCount", int'(QueueCount), 1);
        Left = 1'b0; Up = 1'b0;
        wait_req(r1);
        chk("tick Dir LEFT", int'(Dir), 0);
        ack();

        // Fill queue with (UP, LEFT) while idle; Down while full is dropped
        Run = 1'b0;
        set_btn(0, 0, 1, 0);
        set_btn(1, 0, 1, 0);
        set_btn(1, 0, 1, 1);
        set_btn(0, 0, 0, 0);
        @(negedge Clk);
        chk("full QueueCount", int'(QueueCount), 2);
        chk("idle no request", int'(StepReq), 0);

        // Down pressed exactly on the tick pop edge is accepted
        Run = 1'b1;
        repeat (20) @(negedge Clk);
        Down = 1'b1;
        @(negedge Clk);
        chk("pop+push Dir UP", int'(Dir), 2);
        chk("pop+push QueueCount", int'(QueueCount), 2);
        chk("pop+push StepReq", int'(StepReq), 1);
        Down = 1'b0;

        // Clear in the middle of a handshake with a full queue
        Clear = 1'b1;
        @(negedge Clk); Clear = 1'b0;
        chk("clear StepReq", int'(StepReq), 0);
        chk("clear QueueCount", int'(QueueCount), 0);
        chk("clear Dir", int'(Dir), 1);
        chk("clear StepCount", int'(StepCount), 0);

        // Overrun with Period 3 and no acknowledge
        Period = 3;
        wait_req(r1);
        chk("ovr at entry", int'(Overrun), 0);
        @(posedge Clk); #1; chk("ovr req+1", int'(Overrun), 0);
        @(posedge Clk); #1; chk("ovr req+2", int'(Overrun), 0);
        @(posedge Clk); #1; chk("ovr req+3", int'(Overrun), 1);
        chk("ovr StepReq held", int'(StepReq), 1);
        chk("ovr StepCount", int'(StepCount), 0);
        ack();
        chk("late ack StepCount", int'(StepCount), 1);
        chk("ovr sticky", int'(Overrun), 1);

        // Ack outside REQ is ignored; Period 0 behaves as 1
        Run = 1'b0;
        @(negedge Clk); StepAck = 1'b1;
        @(negedge Clk); StepAck = 1'b0;
        chk("stray ack", int'(StepCount), 1);
        Period = 0; Run = 1'b1; t_run = cyc;
        wait_req(r1); chk("latency P=0", r1 - t_run, 2); ack();
        wait_req(r2); chk("spacing P=0 a", r2 - r1, 2); ack();
        wait_req(r3); chk("spacing P=0 b", r3 - r2, 2); ack();
        chk("P=0 StepCount", int'(StepCount), 4);

        // Reset mid-handshake, then an ack after release is ignored
        wait_req(r1);
        @(negedge Clk); Reset = 1'b1; Run = 1'b0;
        #1;
        chk("async reset StepReq", int'(StepReq), 0);
        chk("async reset Dir", int'(Dir), 1);
        chk("async reset StepCount", int'(StepCount), 0);
        @(negedge Clk); Reset = 1'b0; StepAck = 1'b1;
        @(negedge Clk); StepAck = 1'b0;
        chk("post-reset ack StepCount", int'(StepCount), 0);
        chk("post-reset StepReq", int'(StepReq), 0);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
